// File: rtl/bp_pkg.sv
// Shared branch-predictor types and helpers: state encoding, saturating counter step, defaults.
// Latency: n/a (package only; functions are purely combinational).
// Backpressure: n/a.
package bp_pkg;

   // Table walker / run state of the branch history table.
   typedef enum logic [0:0] {
      BHT_CLEAR = 1'b0,
      BHT_RUN   = 1'b1
   } bht_state_t;

   // Widest confidence counter any predictor in this family uses.
   localparam int MAX_CNT_W = 4;

   // Default counter width and its strongly-taken initial value.
   localparam int DEF_CNT_W    = 2;
   localparam int DEF_INIT_CNT = (1 << DEF_CNT_W) - 1;

   // One saturating step toward the resolved outcome; max_val is the
   // all-ones value of the caller's real counter width.
   function automatic logic [MAX_CNT_W-1:0] sat_step(
      input logic [MAX_CNT_W-1:0] cnt,
      input logic                 taken,
      input logic [MAX_CNT_W-1:0] max_val
   );
      logic [MAX_CNT_W-1:0] nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != max_val) nxt = cnt + MAX_CNT_W'(1);
      end else begin
         if (cnt != '0) nxt = cnt - MAX_CNT_W'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Next-value logic for one saturating confidence counter.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module sat_counter_update
   import bp_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic             taken,
   output logic [CNT_W-1:0] next_cnt
);

   localparam logic [MAX_CNT_W-1:0] MAX_V = MAX_CNT_W'((1 << CNT_W) - 1);

   // Widen to the shared helper's width, step, and narrow back.
   always_comb begin
      next_cnt = CNT_W'(sat_step(MAX_CNT_W'(cnt), taken, MAX_V));
   end

endmodule

// File: rtl/branch_history_table.sv
// Table of saturating confidence counters indexed by fetch PC (optionally gshare), with clear walker and stats.
// Latency: prediction is combinational from pred_pc; updates land at the next clock edge, clear takes ENTRIES cycles.
// Backpressure: none on lookup; updates are dropped while ready is low (table being initialised).
module branch_history_table
   import bp_pkg::*;
#(
   parameter int  ENTRIES  = 16,
   parameter int  PC_W     = 32,
   parameter int  CNT_W    = DEF_CNT_W,
   parameter int  INIT_CNT = (1 << CNT_W) - 1,
   parameter bit  GSHARE   = 1'b0,
   parameter int  STAT_W   = 32,
   localparam int IDX_W    = $clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              ready,
   input  logic [PC_W-1:0]   pred_pc,
   output logic              pred_taken,
   output logic [IDX_W-1:0]  pred_idx,
   input  logic              upd_valid,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic              upd_taken,
   input  logic              upd_mispred,
   output logic [STAT_W-1:0] branch_cnt,
   output logic [STAT_W-1:0] mispred_cnt
);

   localparam logic [CNT_W-1:0] INIT_V   = CNT_W'(INIT_CNT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   bht_state_t       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ghr;
   logic [CNT_W-1:0] cnt_tab [ENTRIES];

   logic [IDX_W-1:0] base_idx;
   logic [CNT_W-1:0] upd_cur;
   logic [CNT_W-1:0] upd_next;
   logic             run_upd;
   logic             unused_pc_bits;

   assign base_idx       = pred_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};
   assign run_upd        = (state == BHT_RUN) && upd_valid;

   // Index selection: bimodal uses the PC slice directly, gshare folds in resolved history.
   generate
      if (GSHARE) begin : g_gshare
         assign pred_idx = base_idx ^ ghr;
      end else begin : g_bimodal
         assign pred_idx = base_idx;
      end
   endgenerate

   // Lookup reads the table directly (no bypass); while clearing, report the init value.
   always_comb begin
      pred_taken = INIT_V[CNT_W-1];
      if (state == BHT_RUN) pred_taken = cnt_tab[pred_idx][CNT_W-1];
   end

   assign upd_cur = cnt_tab[upd_idx];

   sat_counter_update #(
      .CNT_W (CNT_W)
   ) u_sat (
      .cnt      (upd_cur),
      .taken    (upd_taken),
      .next_cnt (upd_next)
   );

   // Walker/run FSM with registered ready; owns the clear pointer and the resolved-outcome history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BHT_CLEAR;
         ptr   <= '0;
         ghr   <= '0;
         ready <= 1'b0;
      end else begin
         case (state)
            BHT_CLEAR: begin
               // clr_req and updates are deliberately ignored while walking.
               ptr <= ptr + IDX_W'(1);
               if (ptr == LAST_IDX) begin
                  state <= BHT_RUN;
                  ready <= 1'b1;
               end
            end
            BHT_RUN: begin
               if (clr_req) begin
                  state <= BHT_CLEAR;
                  ptr   <= '0;
                  ghr   <= '0;
                  ready <= 1'b0;
               end else if (upd_valid) begin
                  ghr <= {ghr[IDX_W-2:0], upd_taken};
               end
            end
            default: begin
               state <= BHT_CLEAR;
               ptr   <= '0;
               ready <= 1'b0;
            end
         endcase
      end
   end

   // Table writes: the walker initialises one entry per cycle, otherwise apply resolved outcomes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == BHT_CLEAR) begin
            cnt_tab[ptr] <= INIT_V;
         end else if (upd_valid) begin
            cnt_tab[upd_idx] <= upd_next;
         end
      end
   end

   // Statistics survive a table clear and saturate rather than wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (run_upd) begin
         if (branch_cnt != '1) branch_cnt <= branch_cnt + STAT_W'(1);
         if (upd_mispred && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + STAT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench: bimodal (a), gshare (g) and 4-bit-stat (s) instances driven by one stimulus stream.
// Latency: checks sampled 1 time unit after the rising edge, or after a settle delay for combinational reads.
// Backpressure: n/a.
module tb_branch_history_table;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_req = 1'b0;
   logic [31:0] pred_pc = '0;
   logic        upd_valid = 1'b0;
   logic [3:0]  upd_idx = '0;
   logic        upd_taken = 1'b0;
   logic        upd_mispred = 1'b0;

   logic        ready_a, ready_g, ready_s;
   logic        pred_taken_a, pred_taken_g, pred_taken_s;
   logic [3:0]  pred_idx_a, pred_idx_g, pred_idx_s;
   logic [31:0] branch_cnt_a, mispred_cnt_a, branch_cnt_g, mispred_cnt_g;
   logic [3:0]  branch_cnt_s, mispred_cnt_s;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_history_table #(.GSHARE(1'b0)) dut_a (
      .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_a),
      .pred_pc(pred_pc), .pred_taken(pred_taken_a), .pred_idx(pred_idx_a),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
      .branch_cnt(branch_cnt_a), .mispred_cnt(mispred_cnt_a)
   );

   branch_history_table #(.GSHARE(1'b1)) dut_g (
      .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_g),
      .pred_pc(pred_pc), .pred_taken(pred_taken_g), .pred_idx(pred_idx_g),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
      .branch_cnt(branch_cnt_g), .mispred_cnt(mispred_cnt_g)
   );

   branch_history_table #(.GSHARE(1'b0), .STAT_W(4)) dut_s (
      .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_s),
      .pred_pc(pred_pc), .pred_taken(pred_taken_s), .pred_idx(pred_idx_s),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
      .branch_cnt(branch_cnt_s), .mispred_cnt(mispred_cnt_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One resolved branch for one cycle.
   task automatic upd(input logic [3:0] idx, input logic taken, input logic mis);
      upd_valid   = 1'b1;
      upd_idx     = idx;
      upd_taken   = taken;
      upd_mispred = mis;
      tick();
      upd_valid   = 1'b0;
      upd_mispred = 1'b0;
   endtask

   // Combinational lookup of bimodal instance a at a PC.
   task automatic look_a(input string tag, input logic [31:0] pc, input logic exp);
      pred_pc = pc;
      #1;
      chk(tag, {31'd0, pred_taken_a}, {31'd0, exp});
   endtask

   initial begin
      // ---- reset and initial clear walk ----
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pred_pc = 32'h14;
      for (int i = 0; i < 16; i++) begin
         chk("ready_low_after_rst", {31'd0, ready_a}, 32'd0);
         chk("pred_init_during_clear", {31'd0, pred_taken_a}, 32'd1);
         tick();
      end
      chk("ready_cycle17", {31'd0, ready_a}, 32'd1);
      chk("ready_cycle17_s", {31'd0, ready_s}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         look_a("init_entry_taken", 32'(i * 4), 1'b1);
         chk("bimodal_idx", {28'd0, pred_idx_a}, 32'(i));
      end
      look_a("idx_wrap_taken", 32'h40, 1'b1);
      chk("bimodal_idx_wrap", {28'd0, pred_idx_a}, 32'd0);
      chk("branch_cnt_rst", branch_cnt_a, 32'd0);
      chk("mispred_cnt_rst", mispred_cnt_a, 32'd0);
      chk("branch_cnt_s_rst", {28'd0, branch_cnt_s}, 32'd0);

      // ---- saturation on idx 5 (pc 0x14) ----
      upd(4'd5, 1'b0, 1'b0); look_a("sat_dn1_cnt2", 32'h14, 1'b1);
      upd(4'd5, 1'b0, 1'b1); look_a("sat_dn2_cnt1", 32'h14, 1'b0);
      upd(4'd5, 1'b0, 1'b0); look_a("sat_dn3_cnt0", 32'h14, 1'b0);
      upd(4'd5, 1'b0, 1'b0); look_a("sat_dn4_cnt0", 32'h14, 1'b0);
      upd(4'd5, 1'b1, 1'b1); look_a("sat_up1_cnt1", 32'h14, 1'b0);
      upd(4'd5, 1'b1, 1'b0); look_a("sat_up2_cnt2", 32'h14, 1'b1);
      upd(4'd5, 1'b1, 1'b0); look_a("sat_up3_cnt3", 32'h14, 1'b1);

      // ---- gshare: last four outcomes 0,1,1,1 -> ghr 0111 ----
      pred_pc = 32'h0;
      #1;
      chk("gshare_idx_pc0", {28'd0, pred_idx_g}, 32'd7);
      chk("bimodal_idx_pc0", {28'd0, pred_idx_a}, 32'd0);
      pred_pc = 32'h1C;
      #1;
      chk("gshare_idx_pc1c", {28'd0, pred_idx_g}, 32'd0);

      // ---- same-cycle lookup/update hazard on idx 7 ----
      upd(4'd7, 1'b0, 1'b0);
      pred_pc     = 32'h1C;
      upd_valid   = 1'b1;
      upd_idx     = 4'd7;
      upd_taken   = 1'b0;
      upd_mispred = 1'b1;
      #1;
      chk("hazard_pre_update", {31'd0, pred_taken_a}, 32'd1);
      tick();
      upd_valid   = 1'b0;
      upd_mispred = 1'b0;
      chk("hazard_next_cycle", {31'd0, pred_taken_a}, 32'd0);
      upd(4'd3, 1'b1, 1'b0);
      chk("branch_cnt_10", branch_cnt_a, 32'd10);
      chk("mispred_cnt_3", mispred_cnt_a, 32'd3);
      chk("branch_cnt_s_10", {28'd0, branch_cnt_s}, 32'd10);

      // ---- clear mid-run with updates hammering during the walk ----
      clr_req = 1'b1;
      tick();
      clr_req     = 1'b0;
      upd_valid   = 1'b1;
      upd_idx     = 4'd7;
      upd_taken   = 1'b0;
      upd_mispred = 1'b1;
      pred_pc     = 32'h1C;
      for (int i = 0; i < 16; i++) begin
         chk("ready_low_during_clr", {31'd0, ready_a}, 32'd0);
         chk("pred_init_during_clr", {31'd0, pred_taken_a}, 32'd1);
         tick();
      end
      upd_valid   = 1'b0;
      upd_mispred = 1'b0;
      chk("ready_after_clr", {31'd0, ready_a}, 32'd1);
      chk("branch_cnt_kept", branch_cnt_a, 32'd10);
      chk("mispred_cnt_kept", mispred_cnt_a, 32'd3);
      chk("branch_cnt_g_kept", branch_cnt_g, 32'd10);
      pred_pc = 32'h0;
      #1;
      chk("gshare_ghr_cleared", {28'd0, pred_idx_g}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         look_a("entry_reinit", 32'(i * 4), 1'b1);
      end
      upd(4'd7, 1'b0, 1'b0);
      look_a("idx7_from_init_cnt2", 32'h1C, 1'b1);

      // ---- statistics saturation on 4-bit counters ----
      for (int i = 0; i < 20; i++) begin
         upd(4'd2, 1'b1, 1'b1);
      end
      chk("stat4_branch_sat", {28'd0, branch_cnt_s}, 32'd15);
      chk("stat4_mispred_sat", {28'd0, mispred_cnt_s}, 32'd15);
      chk("stat32_branch", branch_cnt_a, 32'd31);
      chk("stat32_mispred", mispred_cnt_a, 32'd23);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("stat4_branch_rst", {28'd0, branch_cnt_s}, 32'd0);
      chk("stat4_mispred_rst", {28'd0, mispred_cnt_s}, 32'd0);
      chk("stat32_branch_rst", branch_cnt_a, 32'd0);
      chk("ready_low_after_rst2", {31'd0, ready_a}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
Parametrised, clocked successor to the single-counter branch predictor: a table of ENTRIES saturating confidence counters indexed from the fetch PC. Optional gshare mode XORs a global history register into the index. The fetch stage performs the lookup; the execute stage writes back the resolved outcome. Adds a table-clear walker and prediction statistics counters.

Parameters:
ENTRIES, 16, number of counters; power of two, 4..1024; IDX_W = log2(ENTRIES).
PC_W, 32, fetch/branch PC width.
CNT_W, 2, counter width; 2..4.
INIT_CNT, 2**CNT_W-1, value loaded on reset/clear; default is strongly taken.
GSHARE, 0, 0 = bimodal index; 1 = index XOR global history.
STAT_W, 32, width of the statistics counters.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
clr_req  in  1  single-cycle request to re-initialise the table
ready  out  1  high when the table is initialised and accepting updates
pred_pc  in  PC_W  PC of the instruction in fetch
pred_taken  out  1  prediction, combinational from pred_pc
pred_idx  out  IDX_W  index used; carried down the pipeline for update
upd_valid  in  1  a resolved branch this cycle
upd_idx  in  IDX_W  index carried from fetch
upd_taken  in  1  actual outcome
upd_mispred  in  1  prediction was wrong
branch_cnt  out  STAT_W  resolved branches since reset
mispred_cnt  out  STAT_W  mispredictions since reset

Behaviour:
- Reset is synchronous and active-high on clk; ports are named clk and rst.
- Index: base = pred_pc[IDX_W+1:2]. When GSHARE=1, index = base XOR ghr[IDX_W-1:0]; otherwise index = base. pred_idx = index.
- pred_taken = MSB of cnt[index]; this is a combinational read with zero latency.
- FSM states:
  - CLEAR: ptr starts at 0. Each cycle writes cnt[ptr]=INIT_CNT, then ptr++. When ptr==ENTRIES-1 is written, go to RUN. Clearing takes exactly ENTRIES cycles.
  - RUN: ready=1.
- Transitions:
  - rst → CLEAR with ptr=0, ghr=0, branch_cnt=0, mispred_cnt=0.
  - clr_req in RUN → CLEAR with ptr=0 and ghr=0. Statistics are kept.
  - clr_req in CLEAR is ignored.
  - rst during CLEAR restarts the walk at 0.
- Outputs during CLEAR: ready=0, pred_taken = MSB of INIT_CNT regardless of the table, and upd_valid is ignored completely (no counter, ghr or stat change).
- Update in RUN when upd_valid=1, applied at the clock edge:
  - upd_taken=1: cnt[upd_idx]++, saturating at 2**CNT_W-1.
  - upd_taken=0: cnt[upd_idx]--, saturating at 0.
  - ghr <= {ghr[IDX_W-2:0], upd_taken}. ghr is non-speculative and updates only on resolution.
  - branch_cnt++. mispred_cnt++ if upd_mispred. Both saturate at all-ones; they never wrap.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value (no bypass). The update is visible on the next cycle.
- upd_mispred is trusted as given; it is not cross-checked against the table.
- Reset values: ready=0, branch_cnt=0, mispred_cnt=0, ghr=0, FSM=CLEAR. pred_taken = MSB of INIT_CNT until RUN.

Decomposition:
- Shared package bp_pkg holds:
  - the state encoding (BHT_CLEAR, BHT_RUN);
  - the saturating-counter increment/decrement function;
  - the default CNT_W/INIT_CNT constants.
- One sub-module, sat_counter_update: combinational next-value logic, with inputs (cnt, taken) and output next cnt, parametrised by CNT_W. It is reused by future tournament predictors.
- The table array, ghr, walker and statistics counters stay in the top module.

Test Plan:
1. Reset: pulse rst for 1 cycle → ready=0 for exactly 16 cycles, ready=1 on cycle 17. All 16 entries read pred_taken=1 (INIT 3). branch_cnt=mispred_cnt=0.
2. Saturation: from 3, issue 4 not-taken updates on idx 5 → cnt 2,1,0,0 and pred_taken 1,0,0,0. Then 1 taken → cnt 1, pred_taken 0. Then 1 more taken → cnt 2, pred_taken 1.
3. Same-cycle hazard: cnt[7]=2; lookup pc=0x1C while updating idx 7 not-taken → pred_taken=1 that cycle, 0 the next cycle.
4. Gshare (GSHARE=1): 3 taken updates give ghr=4'b0111. Lookup pc=0x00 → pred_idx=7. Bimodal build on the same stimulus → pred_idx=0.
5. Clear mid-run: after branch_cnt=10 and mispred_cnt=3, assert clr_req → ready low for 16 cycles. Updates issued during that time are ignored. The table is back at INIT, ghr=0, branch_cnt stays 10, mispred_cnt stays 3.
6. Stats saturation (STAT_W=4): 20 updates, all with upd_mispred=1 → both counters hold 15. Then rst → both read 0.
